// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush/interrupt controller:
// FSM encoding and the default interrupt drain length.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_INT_DRAIN = 3'd1,
        ST_INT_PUSH  = 3'd2,
        ST_INT_VEC   = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam int DRAIN_CYCLES_DEFAULT = 3;
    localparam int DRAIN_W              = 8;
    localparam int STALL_CNT_W          = 8;

endpackage

// File: rtl/int_pending_latch.sv
// Rising-edge detector on the interrupt line plus the pending flag it sets.
// A new edge in the same cycle as the acknowledge wins, so no request is lost.
module int_pending_latch (
    input  logic clk,
    input  logic rst,
    input  logic int_req,
    input  logic int_ack,
    output logic int_pending
);

    logic int_prev;
    logic int_edge;

    assign int_edge = int_req & ~int_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_prev    <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            int_prev <= int_req;
            if (int_edge) begin
                int_pending <= 1'b1;
            end else if (int_ack) begin
                int_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, HLT, and the
// interrupt entry sequence (drain bubbles, push PC, load vector, acknowledge).
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_req,
    input  logic                   branch_taken,
    input  logic                   hlt_ex,
    input  logic                   int_req,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   int_push,
    output logic                   int_vec_sel,
    output logic                   int_ack,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [2:0]             fsm_state
);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_cnt_next;
    logic                 int_pending;

    int_pending_latch u_int_pending_latch (
        .clk         (clk),
        .rst         (rst),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .int_pending (int_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Interrupt entry only from a quiet RUN cycle (no stall, no branch) or from HALT.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            ST_RUN: begin
                if (!stall_req && !branch_taken) begin
                    if (int_pending) begin
                        state_next     = ST_INT_DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end else if (hlt_ex) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_INT_DRAIN: begin
                if (!stall_req) begin
                    if (drain_cnt == '0) begin
                        state_next = ST_INT_PUSH;
                    end else begin
                        drain_cnt_next = drain_cnt - 1'b1;
                    end
                end
            end
            ST_INT_PUSH: state_next = ST_INT_VEC;
            ST_INT_VEC:  state_next = ST_RUN;
            ST_HALT: begin
                if (int_pending) begin
                    state_next     = ST_INT_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        int_push     = 1'b0;
        int_vec_sel  = 1'b0;
        int_ack      = 1'b0;
        case (state)
            ST_INT_DRAIN: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
            ST_INT_PUSH: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                int_push    = 1'b1;
            end
            ST_INT_VEC: begin
                if_id_flush = 1'b1;
                int_vec_sel = 1'b1;
                int_ack     = 1'b1;
            end
            ST_HALT: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
            default: ;
        endcase
        // A stall freezes the front end and bubbles EX/MEM; it masks branch flushes.
        if (stall_req && state != ST_HALT) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            int_push     = 1'b0;
            int_vec_sel  = 1'b0;
            int_ack      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall_req && stall_cycles != {STALL_CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: each step drives one cycle of inputs and queues the expected
// outputs; a negedge monitor pops and compares them.
module tb_pipeline_stall_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall_req = 1'b0;
    logic       branch_taken = 1'b0;
    logic       hlt_ex = 1'b0;
    logic       int_req = 1'b0;
    logic       pc_en, if_id_en, id_ex_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush;
    logic       int_push, int_vec_sel, int_ack;
    logic [7:0] stall_cycles;
    logic [2:0] fsm_state;

    // {pc_en,if_id_en,id_ex_en, if_id_flush,id_ex_flush,ex_mem_flush, int_push,int_vec_sel,int_ack}
    localparam logic [8:0] O_RUN      = 9'b111_000_000;
    localparam logic [8:0] O_STALL    = 9'b000_001_000;
    localparam logic [8:0] O_BR       = 9'b111_110_000;
    localparam logic [8:0] O_RST      = 9'b000_111_000;
    localparam logic [8:0] O_DRAIN    = 9'b011_100_000;
    localparam logic [8:0] O_DRAIN_BR = 9'b011_110_000;
    localparam logic [8:0] O_PUSH     = 9'b011_100_100;
    localparam logic [8:0] O_VEC      = 9'b111_100_011;
    localparam logic [8:0] O_HALT     = 9'b011_100_000;

    logic [17:0] exp_q[$];
    logic [17:0] exp_item;
    logic [8:0]  act_outs;
    int          checks = 0;
    int          fails = 0;

    pipeline_stall_controller dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req    (stall_req),
        .branch_taken (branch_taken),
        .hlt_ex       (hlt_ex),
        .int_req      (int_req),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .int_push     (int_push),
        .int_vec_sel  (int_vec_sel),
        .int_ack      (int_ack),
        .stall_cycles (stall_cycles),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus; chk requests a stall_cycles compare too.
    task automatic step(input logic r, input logic s, input logic b, input logic h,
                        input logic i, input logic [8:0] o, input logic chk,
                        input logic [7:0] cnt);
        @(posedge clk);
        #1;
        rst          = r;
        stall_req    = s;
        branch_taken = b;
        hlt_ex       = h;
        int_req      = i;
        exp_q.push_back({chk, cnt, o});
    endtask

    task automatic steps(input int n, input logic s, input logic [8:0] o);
        for (int k = 0; k < n; k++) step(1'b0, s, 1'b0, 1'b0, 1'b0, o, 1'b0, 8'd0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_item = exp_q.pop_front();
            act_outs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
                        ex_mem_flush, int_push, int_vec_sel, int_ack};
            checks++;
            if (act_outs !== exp_item[8:0]) begin
                fails++;
                $display("FAIL outputs at %0t: got %b required %b (state %0d)",
                         $time, act_outs, exp_item[8:0], fsm_state);
            end
            if (exp_item[17]) begin
                checks++;
                if (stall_cycles !== exp_item[16:9]) begin
                    fails++;
                    $display("FAIL stall_cycles at %0t: got %0d required %0d",
                             $time, stall_cycles, exp_item[16:9]);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, O_RST, 1, 8'd0);
        step(1, 0, 0, 0, 0, O_RST, 1, 8'd0);
        step(0, 0, 0, 0, 0, O_RUN, 1, 8'd0);
        // Load-use stall for one cycle
        step(0, 1, 0, 0, 0, O_STALL, 1, 8'd0);
        step(0, 0, 0, 0, 0, O_RUN, 1, 8'd1);
        // Branch with stall, then branch alone
        step(0, 1, 1, 0, 0, O_STALL, 0, 8'd0);
        step(0, 0, 1, 0, 0, O_BR, 1, 8'd2);
        step(0, 0, 0, 0, 0, O_RUN, 0, 8'd0);
        // Interrupt entry: 3 drain, push, vector/ack, back to RUN
        step(0, 0, 0, 0, 1, O_RUN, 0, 8'd0);
        step(0, 0, 0, 0, 1, O_RUN, 0, 8'd0);
        step(0, 0, 0, 0, 0, O_DRAIN, 1, 8'd2);
        steps(2, 0, O_DRAIN);
        steps(1, 0, O_PUSH);
        steps(1, 0, O_VEC);
        steps(2, 0, O_RUN);
        // Stall twice and branch once inside the drain: drain lasts 5 cycles
        step(0, 0, 0, 0, 1, O_RUN, 0, 8'd0);
        step(0, 0, 0, 0, 0, O_RUN, 0, 8'd0);
        steps(1, 0, O_DRAIN);
        steps(2, 1, O_STALL);
        step(0, 0, 1, 0, 0, O_DRAIN_BR, 0, 8'd0);
        steps(1, 0, O_DRAIN);
        step(0, 0, 0, 0, 0, O_PUSH, 1, 8'd4);
        steps(1, 0, O_VEC);
        steps(2, 0, O_RUN);
        // New edge coinciding with int_ack is kept and serviced again
        step(0, 0, 0, 0, 1, O_RUN, 0, 8'd0);
        step(0, 0, 0, 0, 0, O_RUN, 0, 8'd0);
        steps(3, 0, O_DRAIN);
        steps(1, 0, O_PUSH);
        step(0, 0, 0, 0, 1, O_VEC, 0, 8'd0);
        step(0, 0, 0, 0, 1, O_RUN, 0, 8'd0);
        step(0, 0, 0, 0, 0, O_DRAIN, 0, 8'd0);
        steps(2, 0, O_DRAIN);
        steps(1, 0, O_PUSH);
        steps(1, 0, O_VEC);
        steps(2, 0, O_RUN);
        // HALT for 20 cycles (a stall there is ignored), then interrupt wakes it
        step(0, 0, 0, 1, 0, O_RUN, 0, 8'd0);
        steps(9, 0, O_HALT);
        steps(1, 1, O_HALT);
        steps(10, 0, O_HALT);
        step(0, 0, 0, 0, 1, O_HALT, 1, 8'd5);
        step(0, 0, 0, 0, 0, O_HALT, 0, 8'd0);
        steps(3, 0, O_DRAIN);
        steps(1, 0, O_PUSH);
        steps(1, 0, O_VEC);
        steps(1, 0, O_RUN);
        // Reset in INT_PUSH abandons the sequence
        step(0, 0, 0, 0, 1, O_RUN, 0, 8'd0);
        step(0, 0, 0, 0, 0, O_RUN, 0, 8'd0);
        steps(3, 0, O_DRAIN);
        step(1, 0, 0, 0, 0, O_RST, 0, 8'd0);
        step(1, 0, 0, 0, 0, O_RST, 1, 8'd0);
        step(0, 0, 0, 0, 0, O_RUN, 1, 8'd0);
        steps(4, 0, O_RUN);
        // Saturation of the stall counter
        steps(300, 1, O_STALL);
        step(0, 0, 0, 0, 0, O_RUN, 1, 8'd255);
        step(0, 0, 0, 0, 0, O_RUN, 1, 8'd255);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port stall_req, input, 1 bit: load-use stall request from the hazard/forwarding unit (EX stage).
REQ-004 SHALL have port branch_taken, input, 1 bit: taken branch/jump resolved in EX.
REQ-005 SHALL have port hlt_ex, input, 1 bit: HLT instruction in EX.
REQ-006 SHALL have port int_req, input, 1 bit: external interrupt line (level; rising edge is the event).
REQ-007 SHALL have outputs pc_en, if_id_en, id_ex_en, each 1 bit: write enables for PC, IF/ID and ID/EX.
REQ-008 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_flush, each 1 bit: bubble insertion into the named register.
REQ-009 SHALL have outputs int_push, int_vec_sel, int_ack, each 1 bit: push PC via SP, load PC from the interrupt vector, one-cycle acknowledge.
REQ-010 SHALL have output stall_cycles, 8 bits: saturating count of stall_req cycles.
REQ-011 SHALL have parameter DRAIN_CYCLES, default 3: bubbles issued before interrupt entry.

Function
REQ-012 SHALL implement FSM states RUN, INT_DRAIN, INT_PUSH, INT_VEC, HALT.
REQ-013 RUN with no event: all enables = 1 and all flushes = 0.
REQ-014 stall_req = 1 in any state except HALT: pc_en, if_id_en and id_ex_en = 0, ex_mem_flush = 1, in the same cycle (combinational).
REQ-015 branch_taken = 1 with stall_req = 0: if_id_flush = 1 and id_ex_flush = 1 in the same cycle; enables remain 1.
REQ-016 Priority: rst > stall_req > branch_taken > interrupt entry > hlt_ex.
REQ-017 int_pending SHALL set on a rising edge of int_req (registered previous value), and SHALL clear in the cycle int_ack = 1.
REQ-018 RUN -> INT_DRAIN when int_pending = 1, stall_req = 0 and branch_taken = 0. The drain counter loads DRAIN_CYCLES-1.
REQ-019 INT_DRAIN: pc_en = 0 and if_id_flush = 1. The counter decrements each cycle with stall_req = 0 and holds while stall_req = 1. At 0 -> INT_PUSH.
REQ-020 INT_DRAIN with branch_taken = 1: the flushes of REQ-015 apply and the drain count continues.
REQ-021 INT_PUSH: int_push = 1 and pc_en = 0 for one cycle -> INT_VEC.
REQ-022 INT_VEC: int_vec_sel = 1, pc_en = 1, int_ack = 1 for one cycle -> RUN.
REQ-023 A new int_req edge during INT_DRAIN..INT_VEC SHALL set int_pending again; it SHALL be serviced after returning to RUN. The edge coinciding with int_ack SHALL win (pending stays 1).
REQ-024 RUN with hlt_ex = 1 and no higher-priority event -> HALT.
REQ-025 HALT: pc_en = 0 and if_id_flush = 1; stall_req is ignored. When int_pending = 1 -> INT_DRAIN; otherwise remain in HALT.
REQ-026 stall_cycles SHALL increment on each clock with stall_req = 1 and saturate at 255.

Reset
REQ-027 rst = 1 SHALL asynchronously set state = RUN, drain counter = 0, int_pending = 0, int_req sample = 0, stall_cycles = 0.
REQ-028 While rst = 1, outputs SHALL be forced as follows:
- enables = 0, flushes = 1
- int_push, int_vec_sel, int_ack = 0
REQ-029 Reset asserted mid-interrupt-sequence SHALL abandon the sequence; no int_ack SHALL be issued.

Structure
REQ-030 The state encoding and the DRAIN_CYCLES default SHALL live in shared package pipeline_ctrl_pkg.
REQ-031 Interrupt edge detect plus the pending flag SHALL be sub-module int_pending_latch; the rest is flat.

Verification
REQ-032 Load-use: stall_req = 1 for 1 cycle in RUN -> that cycle pc_en = if_id_en = id_ex_en = 0, ex_mem_flush = 1; next cycle all enables = 1; stall_cycles = 1.
REQ-033 Branch plus stall in the same cycle -> stall outputs only, flushes of IF/ID and ID/EX = 0; branch_taken alone the next cycle -> if_id_flush = id_ex_flush = 1.
REQ-034 Interrupt: int_req edge in RUN -> 3 INT_DRAIN cycles with if_id_flush = 1, then int_push = 1 for 1 cycle, then int_vec_sel = int_ack = 1 for 1 cycle, then RUN.
REQ-035 Stall in drain: stall_req = 1 for 2 cycles during INT_DRAIN -> drain lasts 5 cycles; int_ack occurs exactly once.
REQ-036 HALT: hlt_ex = 1 -> pc_en held at 0 for 20 cycles; an int_req edge -> INT_DRAIN, and int_ack follows 4 cycles later.
REQ-037 Reset/saturation:
- rst asserted during INT_PUSH -> outputs forced immediately, no int_ack.
- stall_req held for 300 cycles -> stall_cycles = 255.
